// File: rtl/mac_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_sequencer_if
//  Description : Storage-write, control and operand-stream signals of the
//                MAC operand sequencer. "slave" is the sequencer side,
//                "master" is the host / downstream side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mac_operand_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 5,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 2
);
    logic              wr_en;
    logic              wr_sel;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_first;
    logic              op_last;
    logic [ROW_W-1:0]  op_row;
    logic [COL_W-1:0]  op_col;
    logic              done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, op_ready,
        input  busy, op_valid, op_a, op_b, op_first, op_last, op_row, op_col, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, op_ready,
        output busy, op_valid, op_a, op_b, op_first, op_last, op_row, op_col, done
    );
endinterface
`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_sequencer
//  Description : Holds A (ROWS x K) and B (K x COLS) in local registers and,
//                on start, streams a[i][k] / b[k][j] pairs for every C[i][j]
//                in row-major order with first/last framing per dot product.
//                Optional macro OPSEQ_STALL_CNT_EN adds a saturating
//                backpressure-cycle counter on port stall_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int K      = 9,
    parameter int AW     = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef OPSEQ_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    mac_operand_sequencer_if.slave bus
);
    localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_K_W   = (K > 1) ? $clog2(K) : 1;
    localparam int c_NA    = ROWS * K;
    localparam int c_NB    = K * COLS;
    localparam int c_AA_W  = (c_NA > 1) ? $clog2(c_NA) : 1;
    localparam int c_AB_W  = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(ROWS - 1);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(COLS - 1);
    localparam logic [c_K_W-1:0]   c_K_MAX   = c_K_W'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand storage: deliberately outside the reset domain so contents
    // survive rst and successive runs.
    logic [DATA_W-1:0] r_mem_a [c_NA];
    logic [DATA_W-1:0] r_mem_b [c_NB];

    logic [c_ROW_W-1:0] r_i, w_ni;
    logic [c_COL_W-1:0] r_j, w_nj;
    logic [c_K_W-1:0]   r_k, w_nk;
    logic               r_valid, r_first, r_last;
    logic [DATA_W-1:0]  r_a, r_b;
    logic               w_load, w_hs, w_final, w_wr_a, w_wr_b;
    logic [c_AA_W-1:0]  w_rd_a;
    logic [c_AB_W-1:0]  w_rd_b;

    assign w_hs    = r_valid & bus.op_ready;
    assign w_final = (r_i == c_ROW_MAX) && (r_j == c_COL_MAX) && (r_k == c_K_MAX);

    // Writes are accepted only in IDLE; a coincident start takes priority.
    assign w_wr_a = (r_state == S_IDLE) & bus.wr_en & ~bus.start & ~bus.wr_sel
                    & (32'(bus.wr_addr) < c_NA);
    assign w_wr_b = (r_state == S_IDLE) & bus.wr_en & ~bus.start & bus.wr_sel
                    & (32'(bus.wr_addr) < c_NB);

    // Read addresses of the pair about to be loaded.
    assign w_rd_a = c_AA_W'(32'(w_ni) * K + 32'(w_nk));
    assign w_rd_b = c_AB_W'(32'(w_nk) * COLS + 32'(w_nj));

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_wr_a) r_mem_a[bus.wr_addr[c_AA_W-1:0]] <= bus.wr_data;
        if (w_wr_b) r_mem_b[bus.wr_addr[c_AB_W-1:0]] <= bus.wr_data;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, pair-load strobe and index advance (k, then j, then i).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ni        = r_i;
        w_nj        = r_j;
        w_nk        = r_k;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                    w_ni        = '0;
                    w_nj        = '0;
                    w_nk        = '0;
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    if (w_final) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load = 1'b1;
                        if (r_k == c_K_MAX) begin
                            w_nk = '0;
                            if (r_j == c_COL_MAX) begin
                                w_nj = '0;
                                w_ni = r_i + 1'b1;
                            end else begin
                                w_nj = r_j + 1'b1;
                            end
                        end else begin
                            w_nk = r_k + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output pair registers: loaded on start / handshake, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            r_valid <= (w_state_nxt == S_RUN);
            if (w_load) begin
                r_i     <= w_ni;
                r_j     <= w_nj;
                r_k     <= w_nk;
                r_a     <= r_mem_a[w_rd_a];
                r_b     <= r_mem_b[w_rd_b];
                r_first <= (w_nk == '0);
                r_last  <= (w_nk == c_K_MAX);
            end else if (w_state_nxt != S_RUN) begin
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

`ifdef OPSEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles a valid pair waited on op_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !bus.op_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.op_valid = r_valid;
    assign bus.op_a     = r_a;
    assign bus.op_b     = r_b;
    assign bus.op_first = r_first;
    assign bus.op_last  = r_last;
    assign bus.op_row   = r_i;
    assign bus.op_col   = r_j;
endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_operand_sequencer
//  Description : Directed self-checking bench for mac_operand_sequencer:
//                full stream, backpressure, ignored writes/starts, reset
//                abort and a multiply-accumulate sum over the stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_operand_sequencer;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int K     = 9;
    localparam int TOTAL = ROWS * COLS * K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] stall_cnt;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] ma [27];
    logic [7:0] mb [27];

    mac_operand_sequencer_if #(.DATA_W(8), .AW(5), .ROW_W(2), .COL_W(2)) bus ();

    mac_operand_sequencer #(
        .DATA_W(8), .ROWS(ROWS), .COLS(COLS), .K(K), .AW(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef OPSEQ_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

`ifndef OPSEQ_STALL_CNT_EN
    assign stall_cnt = 16'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_a(input int n);
        return ma[(n / (COLS * K)) * K + (n % K)];
    endfunction

    function automatic logic [7:0] exp_b(input int n);
        return mb[(n % K) * COLS + ((n / K) % COLS)];
    endfunction

    task automatic wr(input bit sel, input int addr, input logic [7:0] data, input bit upd);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 5'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (upd) begin
            if (sel) mb[addr] = data;
            else     ma[addr] = data;
        end
    endtask

    // mode 0: ready always; 1: backpressure pattern; 2: start+write injected at pair 10
    task automatic run_stream(input int mode, input bit wr_with_start, input int abort_at, input bit mac);
        int n = 0;
        int cyc = 0;
        int stalls = 0;
        int low_left = 0;
        bit did4 = 1'b0;
        bit rdy;
        int acc = 0;
        int results = 0;
        bus.start    = 1'b1;
        bus.op_ready = 1'b1;
        if (wr_with_start) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_addr = 5'd5;
            bus.wr_data = 8'hEE;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        while (n < TOTAL && cyc < 1000) begin
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_valid", bus.op_valid, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_a", bus.op_a, 0);
                chk("abort_b", bus.op_b, 0);
                chk("abort_first", bus.op_first, 0);
                chk("abort_last", bus.op_last, 0);
                chk("abort_row", bus.op_row, 0);
                chk("abort_col", bus.op_col, 0);
                chk("abort_stall", stall_cnt, 0);
                @(negedge clk);
                rst = 1'b0;
                bus.op_ready = 1'b1;
                @(negedge clk);
                return;
            end
            chk("valid", bus.op_valid, 1);
            chk("busy", bus.busy, 1);
            chk("op_a", bus.op_a, exp_a(n));
            chk("op_b", bus.op_b, exp_b(n));
            chk("row", bus.op_row, n / (COLS * K));
            chk("col", bus.op_col, (n / K) % COLS);
            chk("first", bus.op_first, (n % K) == 0);
            chk("last", bus.op_last, (n % K) == K - 1);
            rdy = 1'b1;
            if (mode == 1) begin
                if (!did4 && n == 4) begin
                    did4 = 1'b1;
                    low_left = 3;
                end
                if (low_left > 0) begin
                    rdy = 1'b0;
                    low_left--;
                end else if (did4) begin
                    rdy = (cyc % 2 == 0);
                end
            end
            if (mode == 2 && n == 10) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = 5'd0;
                bus.wr_data = 8'hAA;
            end
            bus.op_ready = rdy;
            if (!rdy) stalls++;
            if (rdy && mac) begin
                if (bus.op_first) acc = 0;
                acc += int'(bus.op_a) * int'(bus.op_b);
                if (bus.op_last) begin
                    chk("mac_sum", acc, 9);
                    results++;
                end
            end
            @(negedge clk);
            if (rdy) n++;
            cyc++;
        end
        bus.start    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.op_ready = 1'b1;
        chk("timeout", (cyc < 1000), 1);
        if (mode == 0) chk("run_len", cyc, TOTAL);
        if (mac) chk("mac_results", results, ROWS * COLS);
        chk("done_pulse", bus.done, 1);
        chk("done_valid", bus.op_valid, 0);
        chk("done_busy", bus.busy, 0);
`ifdef OPSEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stalls);
`endif
        @(negedge clk);
        chk("done_clear", bus.done, 0);
`ifdef OPSEQ_STALL_CNT_EN
        chk("stall_hold", stall_cnt, stalls);
`endif
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.op_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.op_valid, 0);
        chk("rst_a", bus.op_a, 0);
        chk("rst_b", bus.op_b, 0);
        chk("rst_first", bus.op_first, 0);
        chk("rst_last", bus.op_last, 0);
        chk("rst_row", bus.op_row, 0);
        chk("rst_col", bus.op_col, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // a[i][k] = i*9+k, b[k][j] = k+j
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < K; k++)
                wr(1'b0, i * K + k, 8'(i * 9 + k), 1'b1);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < COLS; j++)
                wr(1'b1, k * COLS + j, 8'(k + j), 1'b1);

        run_stream(0, 1'b0, -1, 1'b0);
        run_stream(1, 1'b0, -1, 1'b0);
        run_stream(2, 1'b0, -1, 1'b0);
        run_stream(0, 1'b0, -1, 1'b0);

        // out-of-range writes and write coincident with start are dropped
        wr(1'b0, 27, 8'h77, 1'b0);
        wr(1'b1, 27, 8'h77, 1'b0);
        run_stream(0, 1'b1, -1, 1'b0);

        // reset abort at pair 40, then a clean restart
        run_stream(0, 1'b0, 40, 1'b0);
        run_stream(0, 1'b0, -1, 1'b0);

        // all-ones fill: every dot product sums to K
        for (int a = 0; a < 27; a++) wr(1'b0, a, 8'd1, 1'b1);
        for (int a = 0; a < 27; a++) wr(1'b1, a, 8'd1, 1'b1);
        run_stream(1, 1'b0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
